// File: rtl/branch_predict_fetch_if.sv
// Fetch/resolve bundle between the PC sequencer, the instruction memory side and the EX stage.
// fetch_valid qualifies pc/pred_* each cycle (no back-pressure; stall holds pc); ex_valid qualifies ex_*.
`timescale 1ns/1ps
interface branch_predict_fetch_if #(
    parameter int PC_WIDTH = 32
);
    logic                stall;
    logic [PC_WIDTH-1:0] pc;
    logic                fetch_valid;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] pred_target;
    logic                ex_valid;
    logic                ex_is_branch;
    logic [PC_WIDTH-1:0] ex_pc;
    logic                ex_taken;
    logic [PC_WIDTH-1:0] ex_target;
    logic                ex_pred_taken;
    logic [PC_WIDTH-1:0] ex_pred_target;
    logic                flush;
    logic [15:0]         mispredict_count;

    modport master (
        input  stall, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output pc, fetch_valid, pred_taken, pred_target, flush, mispredict_count
    );

    modport slave (
        output stall, ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  pc, fetch_valid, pred_taken, pred_target, flush, mispredict_count
    );
endinterface

// File: rtl/branch_predict_fetch.sv
// Fetch PC sequencer with a direct-mapped BTB and 2-bit direction counters;
// redirects and flushes on EX-stage branch mispredicts.
`timescale 1ns/1ps
module branch_predict_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter int                  IDX_BITS = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    branch_predict_fetch_if.master bus
);
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = PC_WIDTH - IDX_BITS - 2;

    logic [PC_WIDTH-1:0] r_pc;
    logic                r_fetch_valid;
    logic [15:0]         r_mcount;
    logic                r_valid  [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [TAG_W-1:0]    r_tag    [ENTRIES];
    logic [PC_WIDTH-1:0] r_target [ENTRIES];

    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic                w_hit;
    logic                w_pred_taken;
    logic [PC_WIDTH-1:0] w_pc_plus4;
    logic [PC_WIDTH-1:0] w_pred_target;
    logic                w_resolve;
    logic                w_mispredict;
    logic [IDX_BITS-1:0] w_ex_idx;
    logic [TAG_W-1:0]    w_ex_tag;
    logic                w_ex_hit;
    logic [1:0]          w_ctr_next;
    logic [PC_WIDTH-1:0] w_next_pc;

    // Lookup on the current fetch PC always sees the table as it was before this edge's update.
    assign w_idx         = r_pc[IDX_BITS+1:2];
    assign w_tag         = r_pc[PC_WIDTH-1:IDX_BITS+2];
    assign w_hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_pred_taken  = w_hit && r_ctr[w_idx][1];
    assign w_pc_plus4    = r_pc + PC_WIDTH'(4);
    assign w_pred_target = w_pred_taken ? r_target[w_idx] : w_pc_plus4;

    assign w_resolve    = bus.ex_valid && bus.ex_is_branch;
    assign w_mispredict = w_resolve &&
                          ((bus.ex_taken != bus.ex_pred_taken) ||
                           (bus.ex_taken && bus.ex_pred_taken &&
                            (bus.ex_target != bus.ex_pred_target)));

    assign w_ex_idx = bus.ex_pc[IDX_BITS+1:2];
    assign w_ex_tag = bus.ex_pc[PC_WIDTH-1:IDX_BITS+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    always_comb begin
        w_ctr_next = r_ctr[w_ex_idx];
        if (bus.ex_taken) begin
            if (r_ctr[w_ex_idx] != 2'b11) w_ctr_next = r_ctr[w_ex_idx] + 2'b01;
        end else begin
            if (r_ctr[w_ex_idx] != 2'b00) w_ctr_next = r_ctr[w_ex_idx] - 2'b01;
        end
    end

    // Redirect beats stall; the PC also holds on the first post-reset cycle so RESET_PC is fetched.
    always_comb begin
        w_next_pc = r_pc;
        if (w_mispredict) begin
            w_next_pc = bus.ex_taken ? bus.ex_target : (bus.ex_pc + PC_WIDTH'(4));
        end else if (!bus.stall && r_fetch_valid) begin
            w_next_pc = w_pred_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc          <= {RESET_PC[PC_WIDTH-1:2], 2'b00};
            r_fetch_valid <= 1'b0;
            r_mcount      <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= 2'b01;
            end
        end else begin
            r_pc          <= {w_next_pc[PC_WIDTH-1:2], 2'b00};
            r_fetch_valid <= 1'b1;
            if (w_mispredict && (r_mcount != 16'hFFFF)) r_mcount <= r_mcount + 16'd1;
            if (w_resolve) begin
                if (w_ex_hit) begin
                    r_ctr[w_ex_idx] <= w_ctr_next;
                end else if (bus.ex_taken) begin
                    r_valid[w_ex_idx] <= 1'b1;
                    r_ctr[w_ex_idx]   <= 2'b10;
                end
            end
        end
    end

    // Tag/target storage needs no reset: entries are only trusted through r_valid.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_resolve && bus.ex_taken) begin
            r_target[w_ex_idx] <= bus.ex_target;
            if (!w_ex_hit) r_tag[w_ex_idx] <= w_ex_tag;
        end
    end

    assign bus.pc               = r_pc;
    assign bus.fetch_valid      = r_fetch_valid;
    assign bus.pred_taken       = w_pred_taken;
    assign bus.pred_target      = w_pred_target;
    assign bus.flush            = w_mispredict;
    assign bus.mispredict_count = r_mcount;
endmodule

// File: tb/tb_branch_predict_fetch.sv
// Scoreboarded bench for branch_predict_fetch: directed scenarios then random traffic,
// checked against an array-based reference model of the predictor.
`timescale 1ns/1ps
module tb_branch_predict_fetch;
    localparam int W = 82;  // {pc, pred_taken, pred_target, flush, mispredict_count}

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_predict_fetch_if bus ();
    branch_predict_fetch dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus.master));

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    // Reference model state
    logic [31:0] m_pc;
    bit          m_fv;
    int          m_cnt;
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];

    function automatic int m_index(input logic [31:0] a);
        return int'((a / 4) % 16);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[m_index(a)] && (m_tag[m_index(a)] == a / 64);
    endfunction

    function automatic void m_reset();
        m_pc = 32'h0; m_fv = 0; m_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_ctr[i] = 1; m_tag[i] = '0; m_tgt[i] = '0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs at negedge, record expected outputs, advance the model.
    task automatic drive(input bit rst, input bit stall, input bit ev, input bit eb,
                         input logic [31:0] epc, input bit et, input logic [31:0] etgt,
                         input bit ept, input logic [31:0] eptgt);
        bit pt, res, mis, ehit;
        logic [31:0] ptgt, npc;
        int i;
        @(negedge clk);
        rst_n = rst; bus.stall = stall; bus.ex_valid = ev; bus.ex_is_branch = eb;
        bus.ex_pc = epc; bus.ex_taken = et; bus.ex_target = etgt;
        bus.ex_pred_taken = ept; bus.ex_pred_target = eptgt;

        pt   = m_hit(m_pc) && (m_ctr[m_index(m_pc)] >= 2);
        ptgt = pt ? m_tgt[m_index(m_pc)] : m_pc + 32'd4;
        res  = ev && eb;
        mis  = res && ((et != ept) || (et && ept && etgt != eptgt));
        if (m_fv) exp_q.push_back({m_pc, pt, ptgt, mis, m_cnt[15:0]});

        if (!rst) begin
            m_reset();
        end else begin
            if (mis) npc = et ? etgt : epc + 32'd4;
            else if (!stall && m_fv) npc = ptgt;
            else npc = m_pc;
            m_pc = npc & ~32'h3;
            if (res) begin
                i = m_index(epc);
                ehit = m_hit(epc);
                if (ehit) begin
                    m_ctr[i] = et ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3)
                                  : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                    if (et) m_tgt[i] = etgt;
                end else if (et) begin
                    m_valid[i] = 1; m_tag[i] = epc / 64; m_tgt[i] = etgt; m_ctr[i] = 2;
                end
            end
            if (mis && m_cnt < 65535) m_cnt++;
            m_fv = 1;
        end
    endtask

    task automatic idle(input bit stall);
        drive(1, stall, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic branch(input bit stall, input logic [31:0] epc, input bit et,
                          input logic [31:0] etgt, input bit ept, input logic [31:0] eptgt);
        drive(1, stall, 1, 1, epc, et, etgt, ept, eptgt);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    // Monitor: pops one expectation per valid fetch cycle, sampled mid-low-phase.
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        #3;
        if (bus.fetch_valid === 1'b1) begin
            total++;
            a = {bus.pc, bus.pred_taken, bus.pred_target, bus.flush, bus.mispredict_count};
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL fetch_unexpected t=%0t pc=%h (no expectation queued)", $time, bus.pc);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    bad++;
                    $display("FAIL fetch t=%0t got pc=%h pt=%b ptgt=%h flush=%b cnt=%h expected pc=%h pt=%b ptgt=%h flush=%b cnt=%h",
                             $time, a[81:50], a[49], a[48:17], a[16], a[15:0],
                             e[81:50], e[49], e[48:17], e[16], e[15:0]);
                end
            end
        end
    end

    initial begin
        logic [31:0] epc, etgt, eptgt;
        bit ept;
        m_reset();
        do_reset();
        #3;
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_fetch_valid", {31'b0, bus.fetch_valid}, 32'h0);
        chk("reset_count", {16'b0, bus.mispredict_count}, 32'h0);

        // Sequential fetch after release
        idle(0); idle(0); idle(0); idle(0);
        #3 chk("seq_pc8", bus.pc, 32'h8);

        // Cold taken branch
        branch(0, 32'h10, 1, 32'h40, 0, 32'h14);
        #3 chk("cold_flush", {31'b0, bus.flush}, 32'h1);
        idle(0);
        #3 chk("cold_redirect", bus.pc, 32'h40);
        chk("cold_count", {16'b0, bus.mispredict_count}, 32'h1);

        // Trained prediction
        branch(0, 32'h0, 1, 32'h10, 0, 32'h4);
        idle(0);
        #3 chk("trained_pc", bus.pc, 32'h10);
        chk("trained_pt", {31'b0, bus.pred_taken}, 32'h1);
        chk("trained_ptgt", bus.pred_target, 32'h40);
        branch(0, 32'h10, 1, 32'h40, 1, 32'h40);
        #3 chk("trained_no_flush", {31'b0, bus.flush}, 32'h0);
        chk("trained_follow", bus.pc, 32'h40);

        // Taken to not-taken, twice (counter 11 -> 10 -> 01)
        branch(0, 32'h10, 0, 32'h40, 1, 32'h40);
        #3 chk("nt_flush", {31'b0, bus.flush}, 32'h1);
        branch(0, 32'h10, 0, 32'h40, 1, 32'h40);
        #3 chk("nt_pc14", bus.pc, 32'h14);
        branch(0, 32'h100, 1, 32'h10, 0, 32'h104);
        idle(0);
        #3 chk("nt_weak_pt", {31'b0, bus.pred_taken}, 32'h0);

        // Mispredict during stall
        branch(1, 32'h20, 1, 32'h80, 0, 32'h24);
        idle(1);
        #3 chk("stall_redirect", bus.pc, 32'h80);
        idle(1);
        #3 chk("stall_hold", bus.pc, 32'h80);

        // Aliasing: 0x50 evicts 0x10 at index 4
        branch(0, 32'h10, 1, 32'h40, 0, 32'h14);
        branch(0, 32'h10, 1, 32'h40, 0, 32'h14);
        branch(0, 32'h50, 1, 32'h90, 0, 32'h54);
        branch(0, 32'h200, 1, 32'h10, 0, 32'h204);
        idle(0);
        #3 chk("alias_pc", bus.pc, 32'h10);
        chk("alias_pt", {31'b0, bus.pred_taken}, 32'h0);

        // PC wrap
        do_reset();
        idle(0); idle(0);
        branch(0, 32'h20, 1, 32'hFFFF_FFFC, 0, 32'h24);
        idle(0);
        #3 chk("wrap_top", bus.pc, 32'hFFFF_FFFC);
        idle(0);
        #3 chk("wrap_zero", bus.pc, 32'h0);

        // Mid-sequence reset clears the BTB
        branch(0, 32'h10, 1, 32'h40, 0, 32'h14);
        do_reset();
        for (int k = 0; k < 6; k++) idle(0);
        #3 chk("rst_clear_pc", bus.pc, 32'h10);
        chk("rst_clear_pt", {31'b0, bus.pred_taken}, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 500; n++) begin
            epc  = 32'($urandom_range(0, 127)) * 4;
            etgt = 32'($urandom_range(0, 127)) * 4;
            if ($urandom_range(0, 9) == 0) etgt = etgt | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                ept   = m_hit(epc) && (m_ctr[m_index(epc)] >= 2);
                eptgt = ept ? m_tgt[m_index(epc)] : epc + 32'd4;
            end else begin
                ept   = 1'($urandom_range(0, 1));
                eptgt = 32'($urandom_range(0, 127)) * 4;
            end
            drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
                  epc, 1'($urandom_range(0, 1)), etgt, ept, eptgt);
        end
        idle(0);
        idle(0);
        #4;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_predict_fetch.md
Name: branch_predict_fetch

Overview:
- Fetch-stage PC sequencer with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- Predicts each fetched PC and steers the next PC.
- Consumes the execute-stage branch resolution (taken flag from the branch-condition unit, actual target) and issues flush/redirect on mispredict.
- Sits between the instruction memory address port and the IF/ID register; the resolution port is driven from EX.

Parameters:
- PC_WIDTH, 32, width of all PCs and targets.
- IDX_BITS, 4, log2 of BTB entries (16 entries); index = pc[IDX_BITS+1:2].
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  hold PC (hazard unit); ignored when redirect fires.
- pc  output  PC_WIDTH  current fetch address.
- fetch_valid  output  1  pc is a valid fetch.
- pred_taken  output  1  prediction for current pc (carried down the pipeline).
- pred_target  output  PC_WIDTH  predicted target for current pc (carried down the pipeline).
- ex_valid  input  1  EX stage holds a valid instruction.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_pc  input  PC_WIDTH  PC of EX branch.
- ex_taken  input  1  resolved outcome (branch-condition unit output).
- ex_target  input  PC_WIDTH  resolved taken target.
- ex_pred_taken  input  1  prediction recorded at fetch.
- ex_pred_target  input  PC_WIDTH  target recorded at fetch.
- flush  output  1  kill IF/ID and ID/EX contents this cycle.
- mispredict_count  output  16  saturating mispredict counter.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc=RESET_PC, fetch_valid=0, mispredict_count=0.
  - All BTB valid bits cleared; all counters set to 2'b01 (weakly not-taken).
  - Applies mid-operation, discarding any pending resolution.
- First cycle after reset release: fetch_valid=1 and stays 1.
- Lookup (combinational on pc):
  - idx=pc[IDX_BITS+1:2], tag=pc[PC_WIDTH-1:IDX_BITS+2].
  - hit = valid[idx] and tag match.
  - pred_taken = hit and ctr[idx][1]; pred_target = btb_target[idx] when pred_taken, else pc+4.
- Resolution (combinational): resolve = ex_valid and ex_is_branch.
- Mispredict = resolve and (ex_taken != ex_pred_taken, or ex_taken and ex_pred_taken and ex_target != ex_pred_target).
- flush = mispredict, asserted in the same cycle.
- Next-PC priority:
  1. Reset.
  2. Mispredict: pc <= ex_taken ? ex_target : ex_pc+4.
  3. stall: pc holds.
  4. Otherwise: pc <= pred_target.
- Arithmetic: pc+4 and ex_pc+4 wrap modulo 2^PC_WIDTH. Bits [1:0] of every loaded PC are forced to 0.
- Table update at the edge when resolve=1, regardless of stall; index/tag taken from ex_pc:
  - Entry hit: counter increments if ex_taken, decrements otherwise, saturating at 0 and 3. If ex_taken, target <= ex_target.
  - Entry miss, ex_taken=1: allocate (valid=1, tag, target=ex_target, ctr=2'b10), evicting the previous occupant.
  - Entry miss, ex_taken=0: no change.
- Same-cycle lookup and update to the same index: lookup uses pre-update contents; the new contents are visible from the next cycle.
- mispredict_count: +1 per mispredict cycle; holds at 16'hFFFF.
- Non-branch EX instructions (ex_is_branch=0) and ex_valid=0 never flush or update.

Test Plan:
- Reset behaviour: rst_n low 2 cycles, RESET_PC=0x0 -> pc=0x0, fetch_valid=0. After release, pc sequences 0x0,0x4,0x8 with pred_taken=0 and flush=0.
- Cold taken branch: branch at 0x10 resolves ex_taken=1, ex_target=0x40, ex_pred_taken=0 -> flush=1 for one cycle; next pc=0x40; mispredict_count=1; BTB[4] allocated with ctr=2'b10.
- Trained prediction: fetch 0x10 again -> pred_taken=1, pred_target=0x40, next pc=0x40. Resolve taken with matching target -> flush=0, ctr=2'b11.
- Taken-to-not-taken: resolve 0x10 with ex_taken=0 while predicted taken -> flush=1, pc<=0x14, ctr 11->10. Repeat -> ctr=01, later fetch of 0x10 has pred_taken=0.
- Mispredict during stall: stall=1 with a simultaneous mispredict to 0x80 -> pc=0x80 next cycle (redirect overrides stall).
- Edge cases:
  - Aliasing: 0x50 taken evicts 0x10's entry at idx 4; fetch 0x10 -> hit=0, pred_taken=0.
  - Wrap: pc=0xFFFF_FFFC with no prediction -> next pc=0x0.
  - Reset asserted mid-sequence clears BTB valid bits; a subsequent fetch of 0x10 gives pred_taken=0.
